// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer: per-channel 2-flop synchroniser, stability filter,
// press/release strobes, one-shot long press and optional auto-repeat train.
module key_debounce_array #(
  parameter int NUM_KEYS      = 4,
  parameter int ACTIVE_HIGH   = 1,
  parameter int STABLE_CYCLES = 1000,
  parameter int LONG_CYCLES   = 50000,
  parameter int REPEAT_CYCLES = 10000,
  parameter int CNT_W         = 16,
  parameter int HOLD_W        = 20
) (
  input  logic                debounce_clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  localparam logic              RAW_IDLE   = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_MAX   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_MAX = HOLD_W'(REPEAT_CYCLES - 1);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    logic              s1, s2, norm;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    hold_state_t       state, state_nxt;
    logic              level_q, level_nxt;
    logic              pulse_q, pulse_nxt;
    logic              release_q, release_nxt;
    logic              long_q, long_nxt;
    logic              press_edge, release_edge;

    assign norm = (ACTIVE_HIGH != 0) ? s2 : ~s2;

    always_ff @(posedge debounce_clk) begin
      if (rst) begin
        s1        <= RAW_IDLE;
        s2        <= RAW_IDLE;
        cnt       <= '0;
        hold_cnt  <= '0;
        state     <= IDLE;
        level_q   <= 1'b0;
        pulse_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        s1        <= key[i];
        s2        <= s1;
        cnt       <= cnt_nxt;
        hold_cnt  <= hold_cnt_nxt;
        state     <= state_nxt;
        level_q   <= level_nxt;
        pulse_q   <= pulse_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
      end
    end

    // Any agreeing sample restarts the stability count.
    always_comb begin
      cnt_nxt      = cnt;
      level_nxt    = level_q;
      press_edge   = 1'b0;
      release_edge = 1'b0;
      if (norm == level_q) begin
        cnt_nxt = '0;
      end else if (cnt == STABLE_MAX) begin
        level_nxt    = norm;
        cnt_nxt      = '0;
        press_edge   = norm;
        release_edge = ~norm;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    // A release on a threshold edge wins, so no strobe escapes with the release.
    always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      pulse_nxt    = 1'b0;
      release_nxt  = 1'b0;
      long_nxt     = 1'b0;
      if (release_edge) begin
        release_nxt  = 1'b1;
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end else if (press_edge) begin
        pulse_nxt    = 1'b1;
        state_nxt    = HOLD;
        hold_cnt_nxt = '0;
      end else begin
        case (state)
          HOLD: begin
            if (hold_cnt == LONG_MAX) begin
              long_nxt     = 1'b1;
              pulse_nxt    = repeat_en[i];
              hold_cnt_nxt = '0;
              state_nxt    = REPEAT;
            end else begin
              hold_cnt_nxt = hold_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (hold_cnt == REPEAT_MAX) begin
              pulse_nxt    = repeat_en[i];
              hold_cnt_nxt = '0;
            end else begin
              hold_cnt_nxt = hold_cnt + 1'b1;
            end
          end
          default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
          end
        endcase
      end
    end

    assign key_level[i]   = level_q;
    assign key_pulse[i]   = pulse_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array: bounce, long/repeat, independence,
// reset mid-hold and inverted polarity, with hand-computed edge timing.
module tb_key_debounce_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key, repeat_en, key_n, repeat_en_n;
  logic [1:0] key_level, key_pulse, key_release, key_long;
  logic [1:0] key_level_n, key_pulse_n, key_release_n, key_long_n;

  int checks = 0;
  int errors = 0;
  int runs [6] = '{2, 1, 3, 2, 1, 3};
  logic [1:0] ch1_bounce [9] = '{2'b01, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01};

  key_debounce_array #(
    .NUM_KEYS(2), .ACTIVE_HIGH(1), .STABLE_CYCLES(4), .LONG_CYCLES(10),
    .REPEAT_CYCLES(3), .CNT_W(16), .HOLD_W(20)
  ) dut (
    .debounce_clk(clk), .rst(rst), .key(key), .repeat_en(repeat_en),
    .key_level(key_level), .key_pulse(key_pulse),
    .key_release(key_release), .key_long(key_long)
  );

  key_debounce_array #(
    .NUM_KEYS(2), .ACTIVE_HIGH(0), .STABLE_CYCLES(4), .LONG_CYCLES(10),
    .REPEAT_CYCLES(3), .CNT_W(16), .HOLD_W(20)
  ) dut_n (
    .debounce_clk(clk), .rst(rst), .key(key_n), .repeat_en(repeat_en_n),
    .key_level(key_level_n), .key_pulse(key_pulse_n),
    .key_release(key_release_n), .key_long(key_long_n)
  );

  always #15 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] k, input logic [1:0] r);
    key       = k;
    repeat_en = r;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] lv, input logic [1:0] pu,
                          input logic [1:0] re, input logic [1:0] lo);
    checkOutput({tag, " level"}, key_level, lv);
    checkOutput({tag, " pulse"}, key_pulse, pu);
    checkOutput({tag, " release"}, key_release, re);
    checkOutput({tag, " long"}, key_long, lo);
  endtask

  initial begin
    rst = 1'b1;
    key_n = 2'b11;
    repeat_en_n = 2'b00;
    applyStimulus(2'b00, 2'b00);
    repeat (3) tick();
    checkAll("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("pol reset level", key_level_n, 2'b00);
    rst = 1'b0;
    repeat (6) tick();
    checkAll("idle", 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("pol idle level", key_level_n, 2'b00);

    // Bounce then settle high; press lands 5 edges after the final high is sampled.
    applyStimulus(2'b00, 2'b01);
    for (int r = 0; r < 6; r++) begin
      key[0] = (r % 2 == 0);
      repeat (runs[r]) begin
        tick();
        checkAll("bounce", 2'b00, 2'b00, 2'b00, 2'b00);
      end
    end
    key[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkAll("settle", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick();
    checkAll("bounce press", 2'b01, 2'b01, 2'b00, 2'b00);

    // Long press with repeat, release coinciding with a repeat threshold.
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkAll("repeat hold", 2'b01, (k == 10 || k == 13 || k == 16) ? 2'b01 : 2'b00,
               2'b00, (k == 10) ? 2'b01 : 2'b00);
    end
    key[0] = 1'b0;
    for (int k = 17; k <= 21; k++) begin
      tick();
      checkAll("release wait", 2'b01, (k == 19) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end
    tick();
    checkAll("release", 2'b00, 2'b00, 2'b01, 2'b00);
    repeat (4) begin
      tick();
      checkAll("after release", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Long press without repeat.
    applyStimulus(2'b01, 2'b00);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkAll("norep settle", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick();
    checkAll("norep press", 2'b01, 2'b01, 2'b00, 2'b00);
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkAll("norep hold", 2'b01, 2'b00, 2'b00, (k == 10) ? 2'b01 : 2'b00);
    end
    key[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkAll("norep rel wait", 2'b01, 2'b00, 2'b00, 2'b00);
    end
    tick();
    checkAll("norep release", 2'b00, 2'b00, 2'b01, 2'b00);
    tick();
    checkAll("norep idle", 2'b00, 2'b00, 2'b00, 2'b00);

    // Simultaneous press, then channel 1 bounces low while channel 0 holds.
    applyStimulus(2'b11, 2'b00);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkAll("dual settle", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick();
    checkAll("dual press", 2'b11, 2'b11, 2'b00, 2'b00);
    for (int k = 0; k < 9; k++) begin
      key = ch1_bounce[k];
      tick();
      checkAll("indep", 2'b11, 2'b00, 2'b00, 2'b00);
    end
    key = 2'b11;
    tick();
    checkAll("dual long", 2'b11, 2'b00, 2'b00, 2'b11);
    repeat (2) begin
      tick();
      checkAll("dual steady", 2'b11, 2'b00, 2'b00, 2'b00);
    end
    key = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkAll("dual rel wait", 2'b11, 2'b00, 2'b00, 2'b00);
    end
    tick();
    checkAll("dual release", 2'b00, 2'b00, 2'b11, 2'b00);

    // Reset while in REPEAT, on the edge a repeat pulse would have fired.
    applyStimulus(2'b01, 2'b01);
    for (int k = 0; k < 5; k++) tick();
    tick();
    checkAll("rst press", 2'b01, 2'b01, 2'b00, 2'b00);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkAll("rst hold", 2'b01, (k == 10) ? 2'b01 : 2'b00, 2'b00, (k == 10) ? 2'b01 : 2'b00);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkAll("mid reset", 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkAll("post reset", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick();
    checkAll("repress", 2'b01, 2'b01, 2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00);
    for (int k = 0; k < 5; k++) tick();
    tick();
    checkAll("rst cleanup", 2'b00, 2'b00, 2'b01, 2'b00);

    // Active-low instance: same timing on a falling raw input.
    checkOutput("pol idle2 level", key_level_n, 2'b00);
    key_n[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("pol settle", key_level_n, 2'b00);
    end
    tick();
    checkOutput("pol level", key_level_n, 2'b01);
    checkOutput("pol pulse", key_pulse_n, 2'b01);
    checkOutput("pol release", key_release_n, 2'b00);
    tick();
    checkOutput("pol pulse end", key_pulse_n, 2'b00);
    checkOutput("pol long", key_long_n, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
